// File: rtl/vec_seq_ctrl.sv
// rtl/vec_seq_ctrl.sv - scalar index registers and vector element issue sequencer
module vec_seq_ctrl #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       sca_reg_op,
    input  logic [31:0]      imm,
    output logic [31:0]      i_reg,
    output logic [31:0]      j_reg,
    output logic [CNT_W-1:0] n_reg,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [1:0]       elem_kind,
    output logic [CNT_W-1:0] elem_idx,
    output logic             elem_last,
    output logic             done,
    output logic             err_op
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    localparam logic [2:0] OP_INCRI = 3'b000;
    localparam logic [2:0] OP_INCRJ = 3'b001;
    localparam logic [2:0] OP_SETN  = 3'b010;
    localparam logic [2:0] OP_SUMFV = 3'b011;
    localparam logic [2:0] OP_MULFV = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_LDV   = 3'b111;

    state_t           state_q, state_d;
    logic [31:0]      i_q, i_d, j_q, j_d;
    logic [CNT_W-1:0] n_q, n_d, n_lat_q, n_lat_d, cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;
    logic             done_q, done_d, err_q, err_d;
    logic             issue_w, last_w;

    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:CNT_W];

    assign issue_w = (state_q == S_ISSUE);
    // n_lat is never 0 in ISSUE, so n_lat-1 cannot wrap and the counter stays below n_lat.
    assign last_w  = issue_w && (cnt_q == n_lat_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        n_d     = n_q;
        n_lat_d = n_lat_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (sca_reg_op)
                        OP_INCRI: i_d = i_q + 32'd1;
                        OP_INCRJ: j_d = j_q + 32'd1;
                        OP_SETN:  n_d = imm[CNT_W-1:0];
                        OP_NOP:   ;
                        OP_SUMFV, OP_MULFV, OP_LDV: begin
                            if (n_q == '0) begin
                                done_d = 1'b1;
                            end else begin
                                kind_d  = (sca_reg_op == OP_SUMFV) ? 2'b00 :
                                          (sca_reg_op == OP_MULFV) ? 2'b01 : 2'b10;
                                n_lat_d = n_q;
                                cnt_d   = '0;
                                state_d = S_ISSUE;
                            end
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
                if (elem_ready) begin
                    if (last_w) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            n_lat_q <= '0;
            cnt_q   <= '0;
            kind_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            n_q     <= n_d;
            n_lat_q <= n_lat_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign op_ready   = (state_q == S_IDLE);
    assign elem_valid = issue_w;
    assign elem_kind  = issue_w ? kind_q : 2'b00;
    assign elem_idx   = issue_w ? cnt_q : '0;
    assign elem_last  = last_w;
    assign done       = done_q;
    assign err_op     = err_q;
    assign i_reg      = i_q;
    assign j_reg      = j_q;
    assign n_reg      = n_q;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb/tb_vec_seq_ctrl.sv - randomized and directed bench for vec_seq_ctrl against a queue-based model
module tb_vec_seq_ctrl;

    localparam int CNT_W = 25;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       sca_reg_op = 3'd5;
    logic [31:0]      imm = '0;
    logic [31:0]      i_reg, j_reg;
    logic [CNT_W-1:0] n_reg;
    logic             elem_valid;
    logic             elem_ready = 1'b0;
    logic [1:0]       elem_kind;
    logic [CNT_W-1:0] elem_idx;
    logic             elem_last;
    logic             done, err_op;

    vec_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .sca_reg_op(sca_reg_op), .imm(imm), .i_reg(i_reg), .j_reg(j_reg),
        .n_reg(n_reg), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .elem_kind(elem_kind), .elem_idx(elem_idx), .elem_last(elem_last),
        .done(done), .err_op(err_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] idx;
        logic             last;
    } elem_t;

    // Model: pending elements of the running vector op, in issue order.
    elem_t            q[$];
    logic [31:0]      m_i, m_j;
    logic [CNT_W-1:0] m_n;
    logic             exp_done, exp_err;
    logic             model_ok = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;
    int obs_valid, obs_done, obs_err;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        elem_t hd;
        hd = (q.size() != 0) ? q[0] : '0;
        cmp("op_ready",   32'(op_ready),   32'(q.size() == 0));
        cmp("elem_valid", 32'(elem_valid), 32'(q.size() != 0));
        cmp("elem_idx",   32'(elem_idx),   32'(hd.idx));
        cmp("elem_kind",  32'(elem_kind),  32'(hd.kind));
        cmp("elem_last",  32'(elem_last),  32'(hd.last));
        cmp("done",       32'(done),       32'(exp_done));
        cmp("err_op",     32'(err_op),     32'(exp_err));
        cmp("i_reg",      i_reg,           m_i);
        cmp("j_reg",      j_reg,           m_j);
        cmp("n_reg",      32'(n_reg),      32'(m_n));
    endtask

    task automatic model_update(input logic v, input logic [2:0] o, input logic [31:0] im,
                                input logic rdy, input logic r);
        elem_t e;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            m_i = '0; m_j = '0; m_n = '0;
            q.delete();
        end else if (q.size() != 0) begin
            if (rdy) begin
                if (q[0].last) exp_done = 1'b1;
                q.delete(0);
            end
        end else if (v) begin
            case (o)
                3'd0: m_i = m_i + 32'd1;
                3'd1: m_j = m_j + 32'd1;
                3'd2: m_n = im[CNT_W-1:0];
                3'd5: ;
                3'd3, 3'd4, 3'd7: begin
                    if (m_n == '0) exp_done = 1'b1;
                    else begin
                        for (int k = 0; k < int'(m_n); k++) begin
                            e.kind = (o == 3'd3) ? 2'b00 : (o == 3'd4) ? 2'b01 : 2'b10;
                            e.idx  = CNT_W'(k);
                            e.last = (k == int'(m_n) - 1);
                            q.push_back(e);
                        end
                    end
                end
                default: exp_err = 1'b1;
            endcase
        end
    endtask

    task automatic step(input logic v, input logic [2:0] o, input logic [31:0] im,
                        input logic rdy, input logic r);
        @(negedge clk);
        if (model_ok) begin
            check_all();
            obs_valid += int'(elem_valid);
            obs_done  += int'(done);
            obs_err   += int'(err_op);
        end
        op_valid   = v;
        sca_reg_op = o;
        imm        = im;
        elem_ready = rdy;
        rst        = r;
        model_update(v, o, im, rdy, r);
        if (r) model_ok = 1'b1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b0, 3'd5, 32'd0, rdy, 1'b0);
    endtask

    task automatic clr_obs();
        obs_valid = 0; obs_done = 0; obs_err = 0;
    endtask

    initial begin
        clr_obs();
        step(1'b0, 3'd5, 32'd0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd0, 1'b0, 1'b0);
        clr_obs();
        idle(2, 1'b0);
        cmp("lit_i_after_incr", i_reg, 32'd3);
        cmp("lit_j_after_incr", j_reg, 32'd1);
        cmp("lit_n_after_reset", 32'(n_reg), 32'd0);
        cmp("lit_no_pulses", 32'(obs_done + obs_err), 32'd0);

        step(1'b1, 3'd2, 32'h0000_0004, 1'b1, 1'b0);
        step(1'b1, 3'd3, 32'd0, 1'b1, 1'b0);
        clr_obs();
        idle(7, 1'b1);
        cmp("lit_sumfv_issue_cycles", 32'(obs_valid), 32'd4);
        cmp("lit_sumfv_done_count", 32'(obs_done), 32'd1);

        step(1'b1, 3'd2, 32'd3, 1'b1, 1'b0);
        step(1'b1, 3'd4, 32'd0, 1'b1, 1'b0);
        clr_obs();
        step(1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd5, 32'd0, 1'b0, 1'b0);
        cmp("lit_mulfv_hold_idx", 32'(elem_idx), 32'd1);
        cmp("lit_mulfv_hold_kind", 32'(elem_kind), 32'd1);
        step(1'b0, 3'd5, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd5, 32'd0, 1'b1, 1'b0);
        idle(3, 1'b1);
        cmp("lit_mulfv_issue_cycles", 32'(obs_valid), 32'd5);
        cmp("lit_mulfv_done_count", 32'(obs_done), 32'd1);
        cmp("lit_i_unchanged_in_issue", i_reg, 32'd3);

        step(1'b1, 3'd2, 32'd0, 1'b1, 1'b0);
        step(1'b1, 3'd7, 32'd0, 1'b1, 1'b0);
        clr_obs();
        step(1'b1, 3'd6, 32'd0, 1'b1, 1'b0);
        idle(3, 1'b1);
        cmp("lit_ldv_n0_valid", 32'(obs_valid), 32'd0);
        cmp("lit_ldv_n0_done", 32'(obs_done), 32'd1);
        cmp("lit_illegal_err", 32'(obs_err), 32'd1);
        cmp("lit_illegal_i_kept", i_reg, 32'd3);

        step(1'b1, 3'd2, 32'hFE00_0008, 1'b1, 1'b0);
        step(1'b1, 3'd7, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd5, 32'd0, 1'b1, 1'b0);
        step(1'b0, 3'd5, 32'd0, 1'b1, 1'b0);
        cmp("lit_ldv_n8_masked", 32'(n_reg), 32'd8);
        clr_obs();
        step(1'b0, 3'd5, 32'd0, 1'b1, 1'b1);
        idle(4, 1'b1);
        cmp("lit_abort_done", 32'(obs_done), 32'd0);
        cmp("lit_abort_n", 32'(n_reg), 32'd0);

        @(negedge clk);
        force dut.i_q = 32'hFFFF_FFFF;
        m_i = 32'hFFFF_FFFF;
        idle(1, 1'b0);
        release dut.i_q;
        step(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        idle(1, 1'b0);
        cmp("lit_i_wrap", i_reg, 32'd0);

        for (int k = 0; k < 4000; k++) begin
            logic [31:0] im;
            im = ($urandom & 32'hFE00_0000) | 32'($urandom_range(0, 6));
            step(($urandom_range(0, 9) < 7), 3'($urandom), im,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 199) == 0));
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_seq_ctrl.md
VEC_SEQ_CTRL -- requirements
Module: vec_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, 25, width of vector length register and element index (matches SETN immediate field imm[24:0]).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op_valid  input  1  decoded operation present.
REQ-005 op_ready  output  1  controller can accept an operation this cycle.
REQ-006 sca_reg_op  input  3  decoded opcode: 000 INCRI, 001 INCRJ, 010 SETN, 011 SUMFV, 100 MULFV, 101 NOP, 111 LDV; 110 and X/Z values are illegal.
REQ-007 imm  input  32  decoded immediate; only imm[CNT_W-1:0] is used, and only for SETN.
REQ-008 i_reg  output  32  scalar index register I.
REQ-009 j_reg  output  32  scalar index register J.
REQ-010 n_reg  output  CNT_W  vector length register N.
REQ-011 elem_valid  output  1  element operation offered to vector datapath.
REQ-012 elem_ready  input  1  datapath accepts element operation.
REQ-013 elem_kind  output  2  00 sum, 01 mul, 10 load; 11 never driven.
REQ-014 elem_idx  output  CNT_W  element index of offered operation.
REQ-015 elem_last  output  1  offered element is final of current vector op.
REQ-016 done  output  1  one-cycle pulse on vector op completion.
REQ-017 err_op  output  1  one-cycle pulse on acceptance of illegal opcode.

Function
REQ-018 FSM states: IDLE, ISSUE; op_ready = 1 exactly in IDLE.
REQ-019 Accept = op_valid & op_ready; unaccepted inputs have no effect.
REQ-020 INCRI accept: i_reg <= i_reg + 1 next cycle, wrapping 0xFFFFFFFF -> 0; stay IDLE.
REQ-021 INCRJ accept: j_reg <= j_reg + 1, same wrap rule; stay IDLE.
REQ-022 SETN accept: n_reg <= imm[CNT_W-1:0]; stay IDLE.
REQ-023 NOP accept: no state change; stay IDLE; no pulse.
REQ-024 Illegal opcode accept: err_op = 1 for the following cycle only; no register or state change.
REQ-025 SUMFV/MULFV/LDV accept with n_reg != 0: latch kind (00/01/10) and n_lat = n_reg, clear counter to 0, enter ISSUE next cycle.
REQ-026 SUMFV/MULFV/LDV accept with n_reg == 0: stay IDLE, no elem_valid, done = 1 the following cycle.
REQ-027 ISSUE: elem_valid = 1, elem_idx = counter, elem_kind = latched kind, elem_last = (counter == n_lat - 1).
REQ-028 elem_idx, elem_kind, elem_last SHALL hold stable while elem_valid = 1 and elem_ready = 0.
REQ-029 ISSUE with elem_ready = 1 and elem_last = 0: counter increments; remain ISSUE (one element per cycle max).
REQ-030 ISSUE with elem_ready = 1 and elem_last = 1: return to IDLE next cycle, done = 1 that cycle, op_ready = 1 that cycle.
REQ-031 In IDLE: elem_valid = 0, elem_last = 0; elem_idx and elem_kind drive 0.
REQ-032 done and err_op SHALL never both be 1; each is exactly one cycle wide.
REQ-033 i_reg, j_reg, n_reg are not modified during ISSUE; n_reg equal to 2^CNT_W-1 issues that many elements without counter overflow.

Reset
REQ-034 rst = 1 at a clock edge: state IDLE, i_reg = j_reg = 0, n_reg = 0, counter = 0, elem_valid = done = err_op = 0, op_ready = 1 in the following cycle.
REQ-035 rst asserted mid-ISSUE aborts the vector op: no done pulse, no further elem_valid after the reset edge.
REQ-036 rst takes priority over any simultaneous accept or elem handshake.

Verification
REQ-037 Reset, then INCRI x3, INCRJ x1 -> i_reg = 3, j_reg = 1, n_reg = 0, no done/err_op.
REQ-038 SETN imm = 0x00000004, then SUMFV, elem_ready tied 1 -> elem_idx 0,1,2,3 on 4 consecutive cycles, elem_kind = 00, elem_last only at idx 3, done pulse next cycle, op_ready low for 4 cycles.
REQ-039 SETN 3, MULFV, elem_ready = 0 for 2 cycles at idx 1 -> idx 1 held with elem_kind = 01 stable, total issue 5 cycles, single done.
REQ-040 n_reg = 0, LDV -> no elem_valid, done 1 cycle after accept; then opcode 110 -> err_op pulse, registers unchanged.
REQ-041 SETN 8, LDV, rst at idx 2 -> next cycle IDLE, n_reg = 0, elem_valid = 0, no done.
REQ-042 i_reg preloaded to 0xFFFFFFFF via 2^32-1 INCRI (or force) then INCRI -> i_reg = 0.
